// File: rtl/aurora_rx_sync_ctrl.sv
// Block-sync controller for one Aurora 64b66b RX lane.
// It hunts for sync-header alignment by slipping the gearbox, and after a
// full rotation the SERDES, until enough consecutive legal headers arrive.
// Once locked, it watches the header error rate and drops lock when the
// rate becomes excessive.
module aurora_rx_sync_ctrl #(
  parameter int LOCK_CNT   = 64,
  parameter int ERR_WIN    = 1024,
  parameter int ERR_MAX    = 16,
  parameter int SETTLE_BLK = 4,
  parameter int SLIP_MAX   = 66
) (
  input  logic        clk_rx_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        hdr_valid_i,
  input  logic [1:0]  hdr_i,
  output logic        gbox_slip_o,
  output logic        serdes_slip_o,
  output logic        locked_o,
  output logic [6:0]  slip_cnt_o,
  output logic [15:0] relock_cnt_o,
  output logic [1:0]  state_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(ERR_WIN + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam int SW = $clog2(SETTLE_BLK + 1);

  // Terminal values: the counter reaches its limit on the strobe that finds it here.
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(ERR_WIN - 1);
  localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_MAX - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_BLK - 1);
  localparam logic [6:0]    SLIP_LAST   = 7'(SLIP_MAX - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t          state_q, state_nxt;
  logic [GW-1:0]   good_q, good_nxt;
  logic [WW-1:0]   win_q, win_nxt;
  logic [EW-1:0]   err_q, err_nxt;
  logic [SW-1:0]   settle_q, settle_nxt;
  logic [6:0]      slip_q, slip_nxt;
  logic [15:0]     relock_q, relock_nxt;
  logic            locked_q, locked_nxt;
  logic            gbox_q, gbox_nxt;
  logic            serdes_q, serdes_nxt;
  logic            hdr_legal;

  // Lock-loss counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hdr_legal = hdr_i[1] ^ hdr_i[0];

  // State and all counters/outputs register here; every output is a flop.
  always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_HUNT;
      good_q   <= '0;
      win_q    <= '0;
      err_q    <= '0;
      settle_q <= '0;
      slip_q   <= '0;
      relock_q <= '0;
      locked_q <= 1'b0;
      gbox_q   <= 1'b0;
      serdes_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      good_q   <= good_nxt;
      win_q    <= win_nxt;
      err_q    <= err_nxt;
      settle_q <= settle_nxt;
      slip_q   <= slip_nxt;
      relock_q <= relock_nxt;
      locked_q <= locked_nxt;
      gbox_q   <= gbox_nxt;
      serdes_q <= serdes_nxt;
    end
  end

  // Next-state and next-output logic; slip pulses default low so they last one cycle.
  always_comb begin
    state_nxt  = state_q;
    good_nxt   = good_q;
    win_nxt    = win_q;
    err_nxt    = err_q;
    settle_nxt = settle_q;
    slip_nxt   = slip_q;
    relock_nxt = relock_q;
    locked_nxt = locked_q;
    gbox_nxt   = 1'b0;
    serdes_nxt = 1'b0;
    if (!enable_i) begin
      state_nxt  = ST_HUNT;
      good_nxt   = '0;
      win_nxt    = '0;
      err_nxt    = '0;
      settle_nxt = '0;
      slip_nxt   = '0;
      locked_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (hdr_valid_i) begin
            if (hdr_legal) begin
              if (good_q == GOOD_LAST) begin
                state_nxt  = ST_LOCKED;
                locked_nxt = 1'b1;
                good_nxt   = '0;
                win_nxt    = '0;
                err_nxt    = '0;
              end else begin
                good_nxt = good_q + 1'b1;
              end
            end else begin
              // Pulse is launched here so it is visible during the SLIP cycle.
              good_nxt  = '0;
              state_nxt = ST_SLIP;
              if (slip_q == SLIP_LAST) begin
                serdes_nxt = 1'b1;
                slip_nxt   = '0;
              end else begin
                gbox_nxt = 1'b1;
                slip_nxt = slip_q + 7'd1;
              end
            end
          end
        end
        ST_SLIP: begin
          // Strobes arriving while the pulse is out are ignored.
          state_nxt  = ST_SETTLE;
          settle_nxt = '0;
        end
        ST_SETTLE: begin
          if (hdr_valid_i) begin
            if (settle_q == SETTLE_LAST) begin
              state_nxt  = ST_HUNT;
              settle_nxt = '0;
              good_nxt   = '0;
            end else begin
              settle_nxt = settle_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (hdr_valid_i) begin
            // Loss of lock outranks a window rollover on the same strobe.
            if (!hdr_legal && (err_q == ERR_LAST)) begin
              state_nxt  = ST_HUNT;
              locked_nxt = 1'b0;
              relock_nxt = sat_inc16(relock_q);
              good_nxt   = '0;
              win_nxt    = '0;
              err_nxt    = '0;
            end else if (win_q == WIN_LAST) begin
              win_nxt = '0;
              err_nxt = '0;
            end else begin
              win_nxt = win_q + 1'b1;
              if (!hdr_legal) err_nxt = err_q + 1'b1;
            end
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  assign gbox_slip_o   = gbox_q;
  assign serdes_slip_o = serdes_q;
  assign locked_o      = locked_q;
  assign slip_cnt_o    = slip_q;
  assign relock_cnt_o  = relock_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_aurora_rx_sync_ctrl.sv
// Directed bench for aurora_rx_sync_ctrl with an event scoreboard.
module tb_aurora_rx_sync_ctrl;

  logic        clk_rx_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic        hdr_valid_i;
  logic [1:0]  hdr_i;
  logic        gbox_slip_o;
  logic        serdes_slip_o;
  logic        locked_o;
  logic [6:0]  slip_cnt_o;
  logic [15:0] relock_cnt_o;
  logic [1:0]  state_o;

  localparam int K_GBOX = 0, K_SERDES = 1, K_RISE = 2, K_FALL = 3;

  typedef struct {
    int          kind;
    logic [6:0]  slip;
    logic [15:0] relock;
    logic [1:0]  st;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_locked = 1'b0;

  aurora_rx_sync_ctrl dut (
    .clk_rx_i      (clk_rx_i),
    .rst_n_i       (rst_n_i),
    .enable_i      (enable_i),
    .hdr_valid_i   (hdr_valid_i),
    .hdr_i         (hdr_i),
    .gbox_slip_o   (gbox_slip_o),
    .serdes_slip_o (serdes_slip_o),
    .locked_o      (locked_o),
    .slip_cnt_o    (slip_cnt_o),
    .relock_cnt_o  (relock_cnt_o),
    .state_o       (state_o)
  );

  always #5 clk_rx_i = ~clk_rx_i;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int slip, input int relock, input int st);
    exp_t e;
    e.kind = kind; e.slip = 7'(slip); e.relock = 16'(relock); e.st = 2'(st);
    q.push_back(e);
  endtask

  // One strobe; gap = idle cycles after it (0 keeps strobes back-to-back).
  task automatic send(input logic [1:0] h, input int gap);
    @(negedge clk_rx_i);
    hdr_valid_i = 1'b1;
    hdr_i = h;
    if (gap > 0) begin
      @(negedge clk_rx_i);
      hdr_valid_i = 1'b0;
      repeat (gap - 1) @(negedge clk_rx_i);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk_rx_i);
    hdr_valid_i = 1'b0;
    repeat (n - 1) @(negedge clk_rx_i);
  endtask

  task automatic check_outputs_zero(input string tag, input int relock);
    check({tag, "_gbox"}, int'(gbox_slip_o), 0);
    check({tag, "_serdes"}, int'(serdes_slip_o), 0);
    check({tag, "_locked"}, int'(locked_o), 0);
    check({tag, "_slip_cnt"}, int'(slip_cnt_o), 0);
    check({tag, "_relock"}, int'(relock_cnt_o), relock);
    check({tag, "_state"}, int'(state_o), 0);
  endtask

  // Monitor: every slip pulse and lock edge must match the next queued expectation.
  always @(negedge clk_rx_i) begin
    int   kind;
    exp_t e;
    if (!rst_n_i) begin
      prev_locked = 1'b0;
    end else begin
      kind = -1;
      if (gbox_slip_o || serdes_slip_o)
        check("slip_exclusive", int'(gbox_slip_o & serdes_slip_o), 0);
      if (gbox_slip_o) kind = K_GBOX;
      else if (serdes_slip_o) kind = K_SERDES;
      else if (locked_o && !prev_locked) kind = K_RISE;
      else if (!locked_o && prev_locked) kind = K_FALL;
      prev_locked = locked_o;
      if (kind >= 0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
        end else begin
          e = q.pop_front();
          check("evt_kind", kind, e.kind);
          check("evt_slip_cnt", int'(slip_cnt_o), int'(e.slip));
          check("evt_relock", int'(relock_cnt_o), int'(e.relock));
          check("evt_state", int'(state_o), int'(e.st));
        end
      end
    end
  end

  initial begin
    rst_n_i = 1'b0;
    enable_i = 1'b1;
    hdr_valid_i = 1'b0;
    hdr_i = 2'b00;
    repeat (2) @(negedge clk_rx_i);
    check_outputs_zero("reset", 0);
    rst_n_i = 1'b1;

    // 1: 64 legal headers lock, one clock after the last one.
    push(K_RISE, 0, 0, 3);
    for (int i = 0; i < 63; i++) send(2'b01, 1);
    check("t1_not_locked_at_63", int'(locked_o), 0);
    send(2'b01, 0);
    @(negedge clk_rx_i);
    hdr_valid_i = 1'b0;
    check("t1_lock_latency", int'(locked_o), 1);
    check("t1_state", int'(state_o), 3);
    idle(3);
    check("t1_queue_empty", q.size(), 0);

    // 2: one bad header slips once; the strobe in the SLIP cycle and 4 settle strobes are discarded.
    @(negedge clk_rx_i);
    rst_n_i = 1'b0;
    @(negedge clk_rx_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) send(2'b10, 1);
    push(K_GBOX, 1, 0, 1);
    send(2'b11, 0);
    for (int i = 0; i < 5; i++) send(2'b00, 0);
    idle(2);
    check("t2_state_hunt", int'(state_o), 0);
    check("t2_slip_cnt", int'(slip_cnt_o), 1);
    push(K_RISE, 1, 0, 3);
    for (int i = 0; i < 64; i++) send(2'b01, 0);
    idle(3);
    check("t2_locked", int'(locked_o), 1);
    check("t2_queue_empty", q.size(), 0);

    // 4: 15 errors hold lock, the 16th drops it without a slip.
    for (int i = 0; i < 15; i++) begin
      send(2'b00, 1);
      send(2'b01, 1);
    end
    check("t4_held_at_15", int'(locked_o), 1);
    push(K_FALL, 1, 1, 0);
    send(2'b11, 0);
    @(negedge clk_rx_i);
    hdr_valid_i = 1'b0;
    check("t4_unlock_latency", int'(locked_o), 0);
    idle(4);
    check("t4_relock", int'(relock_cnt_o), 1);
    check("t4_state", int'(state_o), 0);
    check("t4_queue_empty", q.size(), 0);

    // 5: 15 errors in each of three windows, bunched across the rollovers.
    push(K_RISE, 1, 1, 3);
    for (int i = 0; i < 64; i++) send(2'b10, 0);
    for (int i = 0; i < 1009; i++) send(2'b01, 0);
    for (int i = 0; i < 30; i++) send(2'b00, 0);
    for (int i = 0; i < 2018; i++) send(2'b10, 0);
    for (int i = 0; i < 15; i++) send(2'b11, 0);
    idle(3);
    check("t5_locked", int'(locked_o), 1);
    check("t5_state", int'(state_o), 3);
    check("t5_queue_empty", q.size(), 0);

    // 6b: enable low while locked clears everything except the relock count.
    push(K_FALL, 0, 1, 0);
    @(negedge clk_rx_i);
    enable_i = 1'b0;
    @(negedge clk_rx_i);
    check_outputs_zero("t6_enable", 1);
    idle(2);
    enable_i = 1'b1;

    // 3: constant 00 headers -> 65 gearbox slips then one SERDES slip.
    for (int k = 1; k <= 65; k++) push(K_GBOX, k, 1, 1);
    push(K_SERDES, 0, 1, 1);
    for (int i = 0; i < 66 * 6; i++) send(2'b00, 0);
    idle(3);
    check("t3_slip_cnt_wrapped", int'(slip_cnt_o), 0);
    check("t3_state", int'(state_o), 0);
    check("t3_queue_empty", q.size(), 0);

    // 6a: reset during SETTLE clears every output at once.
    push(K_GBOX, 1, 1, 1);
    send(2'b00, 0);
    send(2'b00, 0);
    send(2'b00, 0);
    @(negedge clk_rx_i);
    hdr_valid_i = 1'b0;
    check("t6_in_settle", int'(state_o), 2);
    rst_n_i = 1'b0;
    #1;
    check_outputs_zero("t6_reset", 0);
    idle(2);
    rst_n_i = 1'b1;
    idle(2);
    check("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
